// File: rtl/axis_stream_fifo_pkg.sv
// rtl/axis_stream_fifo_pkg.sv - shared helpers for the AXI-Stream FIFO
//
// Purpose: constant functions used at elaboration time to size pointers and
// to lay out the packed storage word (tdata followed by enabled sidebands).
// Ports: none (package).

package axis_stream_fifo_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  // Width a sideband field occupies in the storage word.
  function automatic int field_width(input int enable, input int width);
    return (enable != 0) ? width : 0;
  endfunction

  // Bit offset of a sideband field: the field sits after tdata and all
  // enabled fields that precede it, in the order keep, last, id, dest, user.
  function automatic int field_offset(
    input int data_width,
    input int keep_w,
    input int last_w,
    input int id_w,
    input int dest_w,
    input int index
  );
    int off;
    off = data_width;
    if (index > 0) off = off + keep_w;
    if (index > 1) off = off + last_w;
    if (index > 2) off = off + id_w;
    if (index > 3) off = off + dest_w;
    return off;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/axis_pipeline_reg.sv
// rtl/axis_pipeline_reg.sv - single valid/ready register stage
//
// Purpose: one output register slice; loads when empty or when its contents
// are being consumed in the same cycle, giving full 1 word/cycle throughput.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_data/in_valid/in_ready upstream handshake
//   out_data/out_valid/out_ready downstream handshake

module axis_pipeline_reg
  import axis_stream_fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
    end
  end

  // Data register needs no reset; it is only observed while out_valid is set.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      out_data <= in_data;
    end
  end

endmodule

// File: rtl/axis_stream_fifo.sv
// rtl/axis_stream_fifo.sv - single-clock AXI-Stream FIFO with optional frame mode
//
// Purpose: buffers s_axis words into a RAM, reads them through a registered
// RAM read and PIPELINE_OUTPUT register stages onto m_axis.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   s_axis_tdata/tkeep/tlast/tid/tdest/tuser, s_axis_tvalid, s_axis_tready
//                                    input stream
//   m_axis_tdata/tkeep/tlast/tid/tdest/tuser, m_axis_tvalid, m_axis_tready
//                                    output stream

module axis_stream_fifo
  import axis_stream_fifo_pkg::*;
#(
  parameter int DEPTH           = 4096,
  parameter int DATA_WIDTH      = 8,
  parameter int KEEP_ENABLE     = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int LAST_ENABLE     = 1,
  parameter int ID_ENABLE       = 0,
  parameter int ID_WIDTH        = 8,
  parameter int DEST_ENABLE     = 0,
  parameter int DEST_WIDTH      = 8,
  parameter int USER_ENABLE     = 1,
  parameter int USER_WIDTH      = 1,
  parameter int FRAME_FIFO      = 0,
  parameter int PIPELINE_OUTPUT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  localparam int AW     = clog2(DEPTH);
  localparam int PTR_W  = AW + 1;
  localparam int KEEP_W = field_width(KEEP_ENABLE, KEEP_WIDTH);
  localparam int LAST_W = field_width(LAST_ENABLE, 1);
  localparam int ID_W   = field_width(ID_ENABLE, ID_WIDTH);
  localparam int DEST_W = field_width(DEST_ENABLE, DEST_WIDTH);
  localparam int USER_W = field_width(USER_ENABLE, USER_WIDTH);
  localparam int KEEP_OFF = field_offset(DATA_WIDTH, KEEP_W, LAST_W, ID_W, DEST_W, 0);
  localparam int LAST_OFF = field_offset(DATA_WIDTH, KEEP_W, LAST_W, ID_W, DEST_W, 1);
  localparam int ID_OFF   = field_offset(DATA_WIDTH, KEEP_W, LAST_W, ID_W, DEST_W, 2);
  localparam int DEST_OFF = field_offset(DATA_WIDTH, KEEP_W, LAST_W, ID_W, DEST_W, 3);
  localparam int USER_OFF = field_offset(DATA_WIDTH, KEEP_W, LAST_W, ID_W, DEST_W, 4);
  localparam int WORD_W   = USER_OFF + USER_W;
  localparam int NST      = PIPELINE_OUTPUT + 1;

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("axis_stream_fifo: DEPTH must be a power of two and at least 2");
  end
  if (FRAME_FIFO != 0 && LAST_ENABLE == 0) begin : g_bad_frame
    $error("axis_stream_fifo: FRAME_FIFO requires LAST_ENABLE");
  end
  if (PIPELINE_OUTPUT < 0 || PIPELINE_OUTPUT > 2) begin : g_bad_pipe
    $error("axis_stream_fifo: PIPELINE_OUTPUT must be 0..2");
  end

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] in_word;
  logic [WORD_W-1:0] out_word;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  commit_ptr;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              rd_load;
  logic [WORD_W-1:0] ram_q;
  logic              ram_valid;

  // Stage 0 is the registered RAM read; stages 1..PIPELINE_OUTPUT are slices.
  logic [WORD_W-1:0] st_data  [NST];
  logic              st_valid [NST];
  logic              st_ready [NST];

  // Sideband inputs that a given configuration drops are folded here.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest, s_axis_tuser};

  // ---------------------------------------------------------------- packing
  assign in_word[DATA_WIDTH-1:0] = s_axis_tdata;
  if (KEEP_W > 0) begin : g_keep_in
    assign in_word[KEEP_OFF +: KEEP_W] = s_axis_tkeep;
  end
  if (LAST_W > 0) begin : g_last_in
    assign in_word[LAST_OFF] = s_axis_tlast;
  end
  if (ID_W > 0) begin : g_id_in
    assign in_word[ID_OFF +: ID_W] = s_axis_tid;
  end
  if (DEST_W > 0) begin : g_dest_in
    assign in_word[DEST_OFF +: DEST_W] = s_axis_tdest;
  end
  if (USER_W > 0) begin : g_user_in
    assign in_word[USER_OFF +: USER_W] = s_axis_tuser;
  end

  // ------------------------------------------------------------ write side
  assign full          = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign s_axis_tready = !full && !rst;
  assign wr_en         = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= in_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
    end
  end

  // In frame mode the reader only sees words up to the last completed frame.
  if (FRAME_FIFO != 0) begin : g_commit
    always_ff @(posedge clk) begin
      if (rst) begin
        commit_ptr <= '0;
      end else if (wr_en && s_axis_tlast) begin
        commit_ptr <= wr_ptr + PTR_W'(1);
      end
    end
  end else begin : g_no_commit
    assign commit_ptr = wr_ptr;
  end

  // ------------------------------------------------------------- read side
  assign empty   = commit_ptr == rd_ptr;
  assign rd_load = !empty && (!ram_valid || st_ready[0]);

  always_ff @(posedge clk) begin
    if (rd_load) begin
      ram_q <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      ram_valid <= 1'b0;
    end else if (rd_load) begin
      rd_ptr    <= rd_ptr + PTR_W'(1);
      ram_valid <= 1'b1;
    end else if (st_ready[0]) begin
      ram_valid <= 1'b0;
    end
  end

  assign st_data[0]               = ram_q;
  assign st_valid[0]              = ram_valid;
  assign st_ready[NST-1]          = m_axis_tready;

  for (genvar i = 0; i < PIPELINE_OUTPUT; i++) begin : g_stage
    axis_pipeline_reg #(
      .WIDTH(WORD_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_data  (st_data[i]),
      .in_valid (st_valid[i]),
      .in_ready (st_ready[i]),
      .out_data (st_data[i+1]),
      .out_valid(st_valid[i+1]),
      .out_ready(st_ready[i+1])
    );
  end

  assign out_word      = st_data[NST-1];
  assign m_axis_tvalid = st_valid[NST-1];

  // -------------------------------------------------------------- unpacking
  assign m_axis_tdata = out_word[DATA_WIDTH-1:0];
  if (KEEP_W > 0) begin : g_keep_out
    assign m_axis_tkeep = out_word[KEEP_OFF +: KEEP_W];
  end else begin : g_keep_def
    assign m_axis_tkeep = '1;
  end
  if (LAST_W > 0) begin : g_last_out
    assign m_axis_tlast = out_word[LAST_OFF];
  end else begin : g_last_def
    assign m_axis_tlast = 1'b1;
  end
  if (ID_W > 0) begin : g_id_out
    assign m_axis_tid = out_word[ID_OFF +: ID_W];
  end else begin : g_id_def
    assign m_axis_tid = '0;
  end
  if (DEST_W > 0) begin : g_dest_out
    assign m_axis_tdest = out_word[DEST_OFF +: DEST_W];
  end else begin : g_dest_def
    assign m_axis_tdest = '0;
  end
  if (USER_W > 0) begin : g_user_out
    assign m_axis_tuser = out_word[USER_OFF +: USER_W];
  end else begin : g_user_def
    assign m_axis_tuser = '0;
  end

endmodule

// File: tb/tb_axis_stream_fifo.sv
// tb/tb_axis_stream_fifo.sv - self-checking bench for axis_stream_fifo
//
// Instances: 0 = PIPELINE_OUTPUT 1, 1 = PIPELINE_OUTPUT 0, 2 = PIPELINE_OUTPUT 2,
// 3 = frame mode with tlast, PIPELINE_OUTPUT 1. All DEPTH 8, 32-bit data.

module tb_axis_stream_fifo;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata  [N];
  logic        s_tvalid [N];
  logic        s_tlast  [N];
  logic        s_tready [N];
  logic        m_tready [N];
  logic [31:0] m_tdata  [N];
  logic [3:0]  m_tkeep  [N];
  logic        m_tvalid [N];
  logic        m_tlast  [N];
  logic [7:0]  m_tid    [N];
  logic [7:0]  m_tdest  [N];
  logic [0:0]  m_tuser  [N];

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  axis_stream_fifo #(
    .DEPTH(8), .DATA_WIDTH(32), .KEEP_ENABLE(0), .KEEP_WIDTH(4), .LAST_ENABLE(0),
    .ID_ENABLE(0), .ID_WIDTH(8), .DEST_ENABLE(0), .DEST_WIDTH(8), .USER_ENABLE(0),
    .USER_WIDTH(1), .FRAME_FIFO(0), .PIPELINE_OUTPUT(1)
  ) dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata[0]), .s_axis_tkeep(4'hF), .s_axis_tvalid(s_tvalid[0]),
    .s_axis_tready(s_tready[0]), .s_axis_tlast(s_tlast[0]), .s_axis_tid(8'h00),
    .s_axis_tdest(8'h00), .s_axis_tuser(1'b0),
    .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tready(m_tready[0]), .m_axis_tlast(m_tlast[0]), .m_axis_tid(m_tid[0]),
    .m_axis_tdest(m_tdest[0]), .m_axis_tuser(m_tuser[0])
  );

  axis_stream_fifo #(
    .DEPTH(8), .DATA_WIDTH(32), .KEEP_ENABLE(0), .KEEP_WIDTH(4), .LAST_ENABLE(0),
    .ID_ENABLE(0), .ID_WIDTH(8), .DEST_ENABLE(0), .DEST_WIDTH(8), .USER_ENABLE(0),
    .USER_WIDTH(1), .FRAME_FIFO(0), .PIPELINE_OUTPUT(0)
  ) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata[1]), .s_axis_tkeep(4'hF), .s_axis_tvalid(s_tvalid[1]),
    .s_axis_tready(s_tready[1]), .s_axis_tlast(s_tlast[1]), .s_axis_tid(8'h00),
    .s_axis_tdest(8'h00), .s_axis_tuser(1'b0),
    .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tready(m_tready[1]), .m_axis_tlast(m_tlast[1]), .m_axis_tid(m_tid[1]),
    .m_axis_tdest(m_tdest[1]), .m_axis_tuser(m_tuser[1])
  );

  axis_stream_fifo #(
    .DEPTH(8), .DATA_WIDTH(32), .KEEP_ENABLE(0), .KEEP_WIDTH(4), .LAST_ENABLE(0),
    .ID_ENABLE(0), .ID_WIDTH(8), .DEST_ENABLE(0), .DEST_WIDTH(8), .USER_ENABLE(0),
    .USER_WIDTH(1), .FRAME_FIFO(0), .PIPELINE_OUTPUT(2)
  ) dut2 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata[2]), .s_axis_tkeep(4'hF), .s_axis_tvalid(s_tvalid[2]),
    .s_axis_tready(s_tready[2]), .s_axis_tlast(s_tlast[2]), .s_axis_tid(8'h00),
    .s_axis_tdest(8'h00), .s_axis_tuser(1'b0),
    .m_axis_tdata(m_tdata[2]), .m_axis_tkeep(m_tkeep[2]), .m_axis_tvalid(m_tvalid[2]),
    .m_axis_tready(m_tready[2]), .m_axis_tlast(m_tlast[2]), .m_axis_tid(m_tid[2]),
    .m_axis_tdest(m_tdest[2]), .m_axis_tuser(m_tuser[2])
  );

  axis_stream_fifo #(
    .DEPTH(8), .DATA_WIDTH(32), .KEEP_ENABLE(0), .KEEP_WIDTH(4), .LAST_ENABLE(1),
    .ID_ENABLE(0), .ID_WIDTH(8), .DEST_ENABLE(0), .DEST_WIDTH(8), .USER_ENABLE(0),
    .USER_WIDTH(1), .FRAME_FIFO(1), .PIPELINE_OUTPUT(1)
  ) dut3 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata[3]), .s_axis_tkeep(4'hF), .s_axis_tvalid(s_tvalid[3]),
    .s_axis_tready(s_tready[3]), .s_axis_tlast(s_tlast[3]), .s_axis_tid(8'h00),
    .s_axis_tdest(8'h00), .s_axis_tuser(1'b0),
    .m_axis_tdata(m_tdata[3]), .m_axis_tkeep(m_tkeep[3]), .m_axis_tvalid(m_tvalid[3]),
    .m_axis_tready(m_tready[3]), .m_axis_tlast(m_tlast[3]), .m_axis_tid(m_tid[3]),
    .m_axis_tdest(m_tdest[3]), .m_axis_tuser(m_tuser[3])
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      s_tdata[i] = '0; s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0; m_tready[i] = 1'b0;
    end
    step(); step();
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (s_tready[i] !== 1'b0) begin
        errors++; $display("FAIL reset_held_tready inst%0d: got %b expected 0", i, s_tready[i]);
      end
    end
    rst = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) begin
        vectors++;
        if (s_tready[i] !== 1'b1 || m_tvalid[i] !== 1'b0) begin
          errors++;
          $display("FAIL reset_idle inst%0d cyc%0d: tready=%b tvalid=%b expected 1/0",
                   i, c, s_tready[i], m_tvalid[i]);
        end
      end
      step();
    end
  endtask

  task automatic test_single();
    m_tready[0] = 1'b1;
    s_tdata[0]  = 32'hDEADBEEF;
    s_tvalid[0] = 1'b1;
    vectors++;
    if (s_tready[0] !== 1'b1) begin
      errors++; $display("FAIL single_tready: got %b expected 1", s_tready[0]);
    end
    step();
    s_tvalid[0] = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      vectors++;
      if (m_tvalid[0] !== 1'b0) begin
        errors++; $display("FAIL single_early_valid edge+%0d: got %b expected 0", c, m_tvalid[0]);
      end
      step();
    end
    vectors++;
    if (m_tvalid[0] !== 1'b1 || m_tdata[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_output: valid=%b data=%h expected 1/deadbeef", m_tvalid[0], m_tdata[0]);
    end
    vectors++;
    if (m_tkeep[0] !== 4'hF || m_tlast[0] !== 1'b1 || m_tid[0] !== 8'h00 ||
        m_tdest[0] !== 8'h00 || m_tuser[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_sideband_defaults: keep=%h last=%b id=%h dest=%h user=%b expected f/1/00/00/0",
               m_tkeep[0], m_tlast[0], m_tid[0], m_tdest[0], m_tuser[0]);
    end
    step();
    vectors++;
    if (m_tvalid[0] !== 1'b0) begin
      errors++; $display("FAIL single_drop_valid: got %b expected 0", m_tvalid[0]);
    end
  endtask

  task automatic test_fill();
    int accepted;
    int got;
    accepted = 0;
    got = 0;
    m_tready[0] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      s_tdata[0]  = 32'(accepted);
      s_tvalid[0] = 1'b1;
      if (s_tready[0]) accepted++;
      step();
    end
    s_tvalid[0] = 1'b0;
    vectors++;
    if (accepted != 10) begin
      errors++; $display("FAIL fill_capacity: accepted %0d expected 10", accepted);
    end
    vectors++;
    if (s_tready[0] !== 1'b0) begin
      errors++; $display("FAIL fill_full_tready: got %b expected 0", s_tready[0]);
    end
    m_tready[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (m_tvalid[0]) begin
        vectors++;
        if (m_tdata[0] !== 32'(got)) begin
          errors++; $display("FAIL fill_order word%0d: got %h expected %h", got, m_tdata[0], got);
        end
        got++;
      end
      step();
    end
    vectors++;
    if (got != 10) begin
      errors++; $display("FAIL fill_drain_count: got %0d expected 10", got);
    end
    vectors++;
    if (s_tready[0] !== 1'b1) begin
      errors++; $display("FAIL fill_tready_back: got %b expected 1", s_tready[0]);
    end
  endtask

  task automatic test_stream();
    int sent, got, first_cyc, bubbles;
    sent = 0; got = 0; first_cyc = -1; bubbles = 0;
    m_tready[0] = 1'b1;
    for (int c = 0; c < 200 && got < 100; c++) begin
      if (m_tvalid[0]) begin
        if (first_cyc < 0) first_cyc = c;
        vectors++;
        if (m_tdata[0] !== 32'h1000 + 32'(got)) begin
          errors++; $display("FAIL stream_data word%0d: got %h expected %h", got, m_tdata[0], 32'h1000 + got);
        end
        got++;
      end else if (got > 0) begin
        bubbles++;
      end
      if (sent < 100) begin
        s_tdata[0]  = 32'h1000 + 32'(sent);
        s_tvalid[0] = 1'b1;
        vectors++;
        if (s_tready[0] !== 1'b1) begin
          errors++; $display("FAIL stream_tready word%0d: got %b expected 1", sent, s_tready[0]);
        end else begin
          sent++;
        end
      end else begin
        s_tvalid[0] = 1'b0;
      end
      step();
    end
    s_tvalid[0] = 1'b0;
    vectors++;
    if (first_cyc != 3) begin
      errors++; $display("FAIL stream_latency: first word at cycle %0d expected 3", first_cyc);
    end
    vectors++;
    if (bubbles != 0 || got != 100) begin
      errors++; $display("FAIL stream_throughput: bubbles=%0d words=%0d expected 0/100", bubbles, got);
    end
  endtask

  task automatic test_random(input int idx);
    logic [31:0] q[$];
    logic [31:0] exp_word;
    logic [31:0] prev_data;
    logic        prev_stall;
    logic        pending;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; pending = 1'b0; prev_data = '0;
    s_tvalid[idx] = 1'b0;
    while (got < 1000 && cyc < 20000) begin
      if (prev_stall) begin
        vectors++;
        if (m_tvalid[idx] !== 1'b1 || m_tdata[idx] !== prev_data) begin
          errors++;
          $display("FAIL random_hold inst%0d cyc%0d: valid=%b data=%h expected 1/%h",
                   idx, cyc, m_tvalid[idx], m_tdata[idx], prev_data);
        end
      end
      m_tready[idx] = ($urandom_range(0, 99) < 60);
      if (m_tvalid[idx] && m_tready[idx]) begin
        vectors++;
        if (q.size() == 0) begin
          errors++; $display("FAIL random_extra inst%0d: got %h expected no word", idx, m_tdata[idx]);
        end else begin
          exp_word = q.pop_front();
          if (m_tdata[idx] !== exp_word) begin
            errors++;
            $display("FAIL random_data inst%0d word%0d: got %h expected %h", idx, got, m_tdata[idx], exp_word);
          end
        end
        got++;
      end
      prev_stall = m_tvalid[idx] && !m_tready[idx];
      prev_data  = m_tdata[idx];
      if (!pending) begin
        if (sent < 1000 && $urandom_range(0, 99) < 60) begin
          s_tdata[idx]  = $urandom;
          s_tvalid[idx] = 1'b1;
          pending       = 1'b1;
        end else begin
          s_tvalid[idx] = 1'b0;
        end
      end
      if (s_tvalid[idx] && s_tready[idx]) begin
        q.push_back(s_tdata[idx]);
        sent++;
        pending = 1'b0;
      end
      step();
      cyc++;
    end
    s_tvalid[idx] = 1'b0;
    m_tready[idx] = 1'b1;
    vectors++;
    if (got != 1000 || sent != 1000 || q.size() != 0) begin
      errors++;
      $display("FAIL random_count inst%0d: sent=%0d got=%0d left=%0d expected 1000/1000/0",
               idx, sent, got, q.size());
    end
  endtask

  task automatic test_frame();
    logic [31:0] exp_data [3];
    int got;
    exp_data[0] = 32'hA0A0_0001; exp_data[1] = 32'hA0A0_0002; exp_data[2] = 32'hA0A0_0003;
    m_tready[3] = 1'b1;
    s_tdata[3] = exp_data[0]; s_tlast[3] = 1'b0; s_tvalid[3] = 1'b1;
    step();
    s_tdata[3] = exp_data[1];
    step();
    s_tvalid[3] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (m_tvalid[3] !== 1'b0) begin
        errors++; $display("FAIL frame_gap_valid cyc%0d: got %b expected 0", c, m_tvalid[3]);
      end
      step();
    end
    s_tdata[3] = exp_data[2]; s_tlast[3] = 1'b1; s_tvalid[3] = 1'b1;
    step();
    s_tvalid[3] = 1'b0; s_tlast[3] = 1'b0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_tvalid[3]) begin
        vectors++;
        if (got > 2 || m_tdata[3] !== exp_data[got > 2 ? 2 : got] || m_tlast[3] !== (got == 2)) begin
          errors++;
          $display("FAIL frame_word%0d: data=%h last=%b", got, m_tdata[3], m_tlast[3]);
        end
        got++;
      end
      step();
    end
    vectors++;
    if (got != 3) begin
      errors++; $display("FAIL frame_count: got %0d expected 3", got);
    end

    // Committed frame held back by the sink plus one uncommitted word, then reset.
    m_tready[3] = 1'b0;
    s_tvalid[3] = 1'b1;
    s_tdata[3] = 32'hB0; s_tlast[3] = 1'b0; step();
    s_tdata[3] = 32'hB1; s_tlast[3] = 1'b1; step();
    s_tdata[3] = 32'hB2; s_tlast[3] = 1'b0; step();
    s_tvalid[3] = 1'b0;
    step(); step();
    vectors++;
    if (m_tvalid[3] !== 1'b1) begin
      errors++; $display("FAIL frame_prereset_valid: got %b expected 1", m_tvalid[3]);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (s_tready[3] !== 1'b0) begin
      errors++; $display("FAIL frame_rst_tready: got %b expected 0", s_tready[3]);
    end
    step();
    rst = 1'b0;
    #1;
    vectors++;
    if (s_tready[3] !== 1'b1 || m_tvalid[3] !== 1'b0) begin
      errors++;
      $display("FAIL frame_after_rst: tready=%b tvalid=%b expected 1/0", s_tready[3], m_tvalid[3]);
    end
    m_tready[3] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (m_tvalid[3] !== 1'b0) begin
        errors++; $display("FAIL frame_stale cyc%0d: got valid with %h expected none", c, m_tdata[3]);
      end
      step();
    end
    s_tdata[3] = 32'hC0; s_tlast[3] = 1'b1; s_tvalid[3] = 1'b1;
    step();
    s_tvalid[3] = 1'b0; s_tlast[3] = 1'b0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_tvalid[3]) begin
        vectors++;
        if (m_tdata[3] !== 32'hC0 || m_tlast[3] !== 1'b1) begin
          errors++; $display("FAIL frame_post_rst_word: data=%h last=%b expected c0/1", m_tdata[3], m_tlast[3]);
        end
        got++;
      end
      step();
    end
    vectors++;
    if (got != 1) begin
      errors++; $display("FAIL frame_post_rst_count: got %0d expected 1", got);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_random(1);
    test_random(2);
    test_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
